fu_complete_arbiter: RTL and testbench
======================================

// Module: fu_complete_arbiter
// PURPOSE
//  Consumer end of the FU completion protocol (complete_valid/complete_data).
//  Captures one result per cycle from each of NUM_FU functional units, which have no backpressure.
//  Buffers each result in a per-FU FIFO and grants one result per cycle, round-robin, onto the CDB.
//  Publishes per-FU slot_free so issue logic launches only when the result is guaranteed room.
// PARAMETERS
//  NUM_FU      4   number of functional units attached (>=2)
//  DEPTH       2   entries per per-FU result FIFO (>=2)
// PORTS
//  clk               in   1               clock
//  rst               in   1               reset, synchronous, active-high
//  flush             in   1               squash all buffered and outgoing results
//  fu_complete_valid in   NUM_FU          per-FU result valid (one-cycle pulse per result)
//  fu_complete_data  in   NUM_FU x cdb_t  per-FU result payload
//  fu_slot_free      out  NUM_FU          issue to FU i permitted this cycle
//  cdb_valid         out  1               broadcast valid (registered)
//  cdb_data          out  cdb_t           broadcast payload (registered)
//  cdb_src           out  $clog2(NUM_FU)  index of FU whose result is on the CDB
//  overflow_err      out  1               sticky: a result arrived at a full FIFO
// BEHAVIOUR
//  Reset/flush:
//   - On rst or flush: all FIFOs empty; cdb_valid=0, cdb_data='0, cdb_src=0; RR pointer=0.
//   - overflow_err is cleared by rst only; flush does not clear it.
//  Capture:
//   - fu_complete_valid[i]=1 at cycle t writes fu_complete_data[i] into FIFO i at the edge ending t.
//   - Writes from every FU in the same cycle are all accepted.
//  Grant:
//   - Each cycle, pick the first non-empty FIFO at or after rr_ptr (wrap NUM_FU-1 -> 0).
//   - Pop that FIFO's head; load it into cdb_data/cdb_src; set cdb_valid=1 at the same edge.
//   - rr_ptr <= granted index + 1, with wrap.
//   - If no FIFO is non-empty: cdb_valid <= 0, cdb_data <= '0, rr_ptr unchanged.
//  Latency:
//   - complete_valid in cycle t -> cdb_valid in cycle t+2 if uncontended.
//   - Worst case: t+1+NUM_FU*DEPTH.
//   - CDB output is not in program order; consumers use cdb_data.order.
//  Simultaneous push+pop on one FIFO:
//   - Count unchanged; head advances; new entry lands at the tail.
//   - Data is never lost or duplicated.
//  fu_slot_free[i]:
//   - Combinational: (count_i + fu_complete_valid[i]) <= DEPTH-2.
//   - Guarantees room for the one in-flight result an FU may hold.
//   - DEPTH=2: high only when FIFO i is empty and FU i is not completing this cycle.
//  Overflow (protocol violation):
//   - A push to a full FIFO with no simultaneous pop drops the incoming entry.
//   - overflow_err <= 1 (sticky); simulation assertion fires.
//  Flush vs capture:
//   - A flush in the same cycle as a fu_complete_valid discards that result.
//   - A flush in the same cycle as a grant discards that grant; cdb_valid=0 next cycle.
//  Width rules:
//   - FIFO pointers are $clog2(DEPTH) bits, wrap modulo DEPTH.
//   - Counts are $clog2(DEPTH+1) bits.
// STRUCTURE
//  Shared package rv32i_types:
//   - cdb_t (valid, rd, data, pc, pc_wdata, inst, order, rs1/rs2 addr+rdata, mem_* fields).
//   - NUM_FU default constant.
//  Sub-module cdb_fifo: sync FIFO, ports push/push_data/pop/head/empty/full/count, rst+flush clear.
//  Top level: NUM_FU x cdb_fifo instances, RR priority picker, output register, overflow flag.
// TESTING
//  1. Single: FU0 valid cycle 5, data=0x1234, rd=3 -> cdb_valid cycle 7, data=0x1234, src=0; idle after.
//  2. All 4 FUs valid cycle 5, rr_ptr=2 -> cdb_src 2,3,0,1 in cycles 7..10; slot_free=0 while buffered.
//  3. FU1 valid every cycle for 10 cycles, others idle -> 10 results in order, 1 per cycle, no overflow.
//  4. Push+pop same FIFO: FU0 valid cycles 5,6 -> outputs cycles 7,8; count never exceeds 1.
//  5. Flush cycle 6 with 3 entries queued and FU2 completing -> cdb_valid=0 from 7; slot_free all 1 by 7.
//  6. DEPTH=2: FU3 pushes 3 times, pops blocked by other FUs -> overflow_err=1; cleared only by rst.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types for the completion path
package rv32i_types;

  localparam int NUM_FU_DEFAULT = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] pc_wdata;
    logic [31:0] inst;
    logic [63:0] order;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } cdb_t;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - small synchronous FIFO holding completed results for one FU
// A push to a full FIFO is accepted only when the head pops in the same cycle.
module cdb_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  cdb_t             push_data,
  input  logic             pop,
  output cdb_t             head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  cdb_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fu_complete_arbiter.sv
// rtl/fu_complete_arbiter.sv - buffers FU completions and grants one per cycle onto the CDB
// Round-robin across per-FU FIFOs; slot_free keeps room for one in-flight result per FU.
module fu_complete_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT,
  parameter int DEPTH  = 2,
  localparam int SRC_W = $clog2(NUM_FU),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NUM_FU-1:0] fu_complete_valid,
  input  cdb_t              fu_complete_data [NUM_FU],
  output logic [NUM_FU-1:0] fu_slot_free,
  output logic              cdb_valid,
  output cdb_t              cdb_data,
  output logic [SRC_W-1:0]  cdb_src,
  output logic              overflow_err
);

  cdb_t              head [NUM_FU];
  logic [CNT_W-1:0]  count [NUM_FU];
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] ovf;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  rr_next;
  logic              grant_valid;
  int                scan_idx;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign push[i] = fu_complete_valid[i] & ~flush;
    assign pop[i]  = grant_valid & (grant_idx == SRC_W'(i)) & ~flush;
    assign ovf[i]  = push[i] & full[i] & ~pop[i];
    assign fu_slot_free[i] =
      (int'(count[i]) + int'(fu_complete_valid[i])) <= (DEPTH - 2);

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push[i]),
      .push_data (fu_complete_data[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .empty     (empty[i]),
      .full      (full[i]),
      .count     (count[i])
    );
  end

  // First non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_FU) begin
        scan_idx = scan_idx - NUM_FU;
      end
      if (!grant_valid && !empty[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(scan_idx);
      end
    end
  end

  assign rr_next = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (grant_valid) begin
      cdb_valid <= 1'b1;
      cdb_data  <= head[grant_idx];
      cdb_src   <= grant_idx;
      rr_ptr    <= rr_next;
    end else begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (|ovf) begin
      overflow_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        assert (!ovf[i])
        else $warning("fu_complete_arbiter: result from FU %0d dropped at full buffer", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// tb/tb_fu_complete_arbiter.sv - directed self-checking bench for fu_complete_arbiter
module tb_fu_complete_arbiter;
  import rv32i_types::*;

  localparam int NUM_FU = 4;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NUM_FU-1:0] fu_complete_valid;
  cdb_t              fu_complete_data [NUM_FU];
  logic [NUM_FU-1:0] fu_slot_free;
  logic              cdb_valid;
  cdb_t              cdb_data;
  logic [1:0]        cdb_src;
  logic              overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_complete_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .fu_complete_valid (fu_complete_valid),
    .fu_complete_data  (fu_complete_data),
    .fu_slot_free      (fu_slot_free),
    .cdb_valid         (cdb_valid),
    .cdb_data          (cdb_data),
    .cdb_src           (cdb_src),
    .overflow_err      (overflow_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  function automatic cdb_t mk(input logic [31:0] d, input logic [4:0] rd, input logic [63:0] ord);
    cdb_t c;
    c       = '0;
    c.valid = 1'b1;
    c.rd    = rd;
    c.data  = d;
    c.order = ord;
    return c;
  endfunction

  task automatic idle_inputs;
    fu_complete_valid = '0;
    for (int i = 0; i < NUM_FU; i++) fu_complete_data[i] = '0;
  endtask

  task automatic test_reset;
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cdb_valid); end
    checks++; if (cdb_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", cdb_data.data); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", cdb_src); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow_err); end
    checks++; if (fu_slot_free !== 4'b1111) begin errors++; $display("FAIL reset_slot_free got %b want 1111", fu_slot_free); end
    tick;
  endtask

  task automatic test_single;
    fu_complete_valid[0] = 1'b1;
    fu_complete_data[0]  = mk(32'h1234, 5'd3, 64'd1);
    sample;
    checks++; if (fu_slot_free !== 4'b1110) begin errors++; $display("FAIL single_slot_c0 got %b want 1110", fu_slot_free); end
    tick;
    idle_inputs;
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", cdb_valid); end
    checks++; if (fu_slot_free !== 4'b1110) begin errors++; $display("FAIL single_slot_c1 got %b want 1110", fu_slot_free); end
    tick;
    sample;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", cdb_valid); end
    checks++; if (cdb_data.data !== 32'h1234) begin errors++; $display("FAIL single_data got %h want 1234", cdb_data.data); end
    checks++; if (cdb_data.rd !== 5'd3) begin errors++; $display("FAIL single_rd got %0d want 3", cdb_data.rd); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL single_src got %0d want 0", cdb_src); end
    tick;
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %0b want 0", cdb_valid); end
    checks++; if (cdb_data !== '0) begin errors++; $display("FAIL single_idle_data got %h want 0", cdb_data.data); end
    tick;
  endtask

  task automatic test_rr_all;
    logic [1:0] exp_src [4];
    logic [3:0] exp_sf  [4];
    exp_src = '{2'd2, 2'd3, 2'd0, 2'd1};
    exp_sf  = '{4'b0100, 4'b1100, 4'b1101, 4'b1111};
    // move rr_ptr to 2 by granting FU1 alone
    fu_complete_valid[1] = 1'b1;
    fu_complete_data[1]  = mk(32'h0AA, 5'd1, 64'd2);
    tick;
    idle_inputs;
    tick;
    sample;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1) begin errors++; $display("FAIL rr_setup got v=%0b src=%0d want v=1 src=1", cdb_valid, cdb_src); end
    tick;
    fu_complete_valid = 4'b1111;
    for (int k = 0; k < NUM_FU; k++) fu_complete_data[k] = mk(32'h100 + k, 5'(k), 64'(10 + k));
    tick;
    idle_inputs;
    sample;
    checks++; if (fu_slot_free !== 4'b0000) begin errors++; $display("FAIL rr_slot_buffered got %b want 0000", fu_slot_free); end
    tick;
    for (int j = 0; j < 4; j++) begin
      sample;
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== exp_src[j] || cdb_data.data !== (32'h100 + 32'(exp_src[j]))) begin
        errors++;
        $display("FAIL rr_grant%0d got v=%0b src=%0d data=%h want v=1 src=%0d data=%h", j, cdb_valid, cdb_src, cdb_data.data, exp_src[j], 32'h100 + 32'(exp_src[j]));
      end
      checks++; if (fu_slot_free !== exp_sf[j]) begin errors++; $display("FAIL rr_slot%0d got %b want %b", j, fu_slot_free, exp_sf[j]); end
      tick;
    end
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %0b want 0", cdb_valid); end
    tick;
  endtask

  task automatic test_stream;
    for (int n = 0; n <= 12; n++) begin
      if (n < 10) begin
        fu_complete_valid    = 4'b0010;
        fu_complete_data[1]  = mk(32'h200 + n, 5'd7, 64'(100 + n));
      end else begin
        idle_inputs;
      end
      sample;
      checks++;
      if (n >= 2 && n <= 11) begin
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_data.data !== 32'(32'h200 + n - 2)) begin
          errors++;
          $display("FAIL stream%0d got v=%0b src=%0d data=%h want v=1 src=1 data=%h", n, cdb_valid, cdb_src, cdb_data.data, 32'h200 + n - 2);
        end
      end else if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream%0d_idle got %0b want 0", n, cdb_valid);
      end
      tick;
    end
    sample;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL stream_ovf got %0b want 0", overflow_err); end
    tick;
  endtask

  task automatic test_back_to_back;
    fu_complete_valid   = 4'b0001;
    fu_complete_data[0] = mk(32'h500, 5'd2, 64'd200);
    tick;
    fu_complete_data[0] = mk(32'h501, 5'd2, 64'd201);
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got %0b want 0", cdb_valid); end
    tick;
    idle_inputs;
    sample;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_data.data !== 32'h500) begin errors++; $display("FAIL b2b_first got v=%0b src=%0d data=%h want v=1 src=0 data=500", cdb_valid, cdb_src, cdb_data.data); end
    tick;
    sample;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_data.data !== 32'h501) begin errors++; $display("FAIL b2b_second got v=%0b src=%0d data=%h want v=1 src=0 data=501", cdb_valid, cdb_src, cdb_data.data); end
    checks++; if (fu_slot_free !== 4'b1111) begin errors++; $display("FAIL b2b_slot got %b want 1111", fu_slot_free); end
    tick;
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", cdb_valid); end
    tick;
  endtask

  task automatic test_flush;
    fu_complete_valid = 4'b1011;
    for (int k = 0; k < NUM_FU; k++) fu_complete_data[k] = mk(32'h600 + k, 5'd4, 64'(300 + k));
    tick;
    fu_complete_valid   = 4'b0100;
    fu_complete_data[2] = mk(32'h6F2, 5'd4, 64'd310);
    flush = 1'b1;
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_c1 got %0b want 0", cdb_valid); end
    tick;
    flush = 1'b0;
    idle_inputs;
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_c2_valid got %0b want 0", cdb_valid); end
    checks++; if (cdb_data !== '0) begin errors++; $display("FAIL flush_c2_data got %h want 0", cdb_data.data); end
    checks++; if (fu_slot_free !== 4'b1111) begin errors++; $display("FAIL flush_slot got %b want 1111", fu_slot_free); end
    tick;
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_c3_valid got %0b want 0", cdb_valid); end
    tick;
  endtask

  task automatic test_overflow;
    logic [1:0]  exp_src  [5];
    logic [31:0] exp_data [5];
    exp_src  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_data = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h3B0};
    fu_complete_valid = 4'b1111;
    for (int k = 0; k < NUM_FU; k++) fu_complete_data[k] = mk(32'h300 + k, 5'd5, 64'(400 + k));
    tick;
    fu_complete_valid   = 4'b1000;
    fu_complete_data[3] = mk(32'h3B0, 5'd5, 64'd410);
    tick;
    fu_complete_data[3] = mk(32'h3C0, 5'd5, 64'd411);
    sample;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_before got %0b want 0", overflow_err); end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) sample;
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== exp_src[j] || cdb_data.data !== exp_data[j]) begin
        errors++;
        $display("FAIL ovf_out%0d got v=%0b src=%0d data=%h want v=1 src=%0d data=%h", j, cdb_valid, cdb_src, cdb_data.data, exp_src[j], exp_data[j]);
      end
      if (j == 1) begin
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow_err); end
      end
      tick;
      idle_inputs;
    end
    sample;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got v=%0b data=%h want v=0", cdb_valid, cdb_data.data); end
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    sample;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_after_flush got %0b want 1", overflow_err); end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sample;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_after_rst got %0b want 0", overflow_err); end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle_inputs;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset;
    test_single;
    test_rr_all;
    test_stream;
    test_back_to_back;
    test_flush;
    test_overflow;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
